// File: rtl/craps_pkg.sv
// Shared definitions for the dice roller: die face range and width, FSM states,
// and the face-advance helper used by the free-running pair counter.
package craps_pkg;

    localparam int unsigned DIE_W = 3;

    typedef logic [DIE_W-1:0] face_t;

    localparam face_t DIE_MIN = 3'd1;
    localparam face_t DIE_MAX = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ROLL = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic face_t next_face(input face_t f);
        return (f == DIE_MAX) ? DIE_MIN : f + 3'd1;
    endfunction

endpackage

// File: rtl/die_pair_counter.sv
// Free-running odometer over the 36 (c1,c2) face pairs; c1 is the fast digit,
// c2 advances only when c1 wraps from 6 back to 1.
module die_pair_counter
    import craps_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    output logic [DIE_W-1:0] c1,
    output logic [DIE_W-1:0] c2
);

    always_ff @(posedge clock) begin
        if (reset) begin
            c1 <= DIE_MIN;
            c2 <= DIE_MIN;
        end else begin
            c1 <= next_face(c1);
            if (c1 == DIE_MAX)
                c2 <= next_face(c2);
        end
    end

endmodule

// File: rtl/dice_roller.sv
// Electronic dice pair: a roll request tumbles the displayed faces from the
// free-running pair counter, then latches the final faces and their sum.
module dice_roller
    import craps_pkg::*;
#(
    parameter int unsigned TUMBLE_DIV   = 4,
    parameter int unsigned ROLL_UPDATES = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             roll,
    output logic [DIE_W-1:0] dice1,
    output logic [DIE_W-1:0] dice2,
    output logic             clock_en,
    output logic [3:0]       sum,
    output logic             busy,
    output logic             done
);

    localparam logic [7:0] DIV_LAST = 8'(TUMBLE_DIV - 1);
    localparam logic [7:0] UPD_LAST = 8'(ROLL_UPDATES - 1);

    state_t           state, state_n;
    logic             roll_q, rise;
    logic [7:0]       div, div_n;
    logic [7:0]       upd, upd_n;
    logic [DIE_W-1:0] c1, c2;
    logic [DIE_W-1:0] dice1_n, dice2_n;
    logic             clock_en_n, done_n;
    logic [3:0]       sum_n;

    die_pair_counter u_counter (
        .clock (clock),
        .reset (reset),
        .c1    (c1),
        .c2    (c2)
    );

    assign rise = roll & ~roll_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_IDLE;
            roll_q   <= 1'b0;
            div      <= '0;
            upd      <= '0;
            dice1    <= DIE_MIN;
            dice2    <= DIE_MIN;
            clock_en <= 1'b0;
            done     <= 1'b0;
            sum      <= 4'd2;
        end else begin
            state    <= state_n;
            roll_q   <= roll;
            div      <= div_n;
            upd      <= upd_n;
            dice1    <= dice1_n;
            dice2    <= dice2_n;
            clock_en <= clock_en_n;
            done     <= done_n;
            sum      <= sum_n;
        end
    end

    always_comb begin
        state_n    = state;
        div_n      = div;
        upd_n      = upd;
        dice1_n    = dice1;
        dice2_n    = dice2;
        clock_en_n = 1'b0;
        done_n     = 1'b0;
        sum_n      = sum;
        busy       = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                // Rises arriving in ROLL/DONE are dropped, not queued.
                if (rise) begin
                    state_n = ST_ROLL;
                    div_n   = '0;
                    upd_n   = '0;
                end
            end
            ST_ROLL: begin
                if (div == DIV_LAST) begin
                    div_n      = '0;
                    dice1_n    = c1;
                    dice2_n    = c2;
                    clock_en_n = 1'b1;
                    upd_n      = upd + 8'd1;
                    if (upd == UPD_LAST)
                        state_n = ST_DONE;
                end else begin
                    div_n = div + 8'd1;
                end
            end
            ST_DONE: begin
                done_n  = 1'b1;
                sum_n   = {1'b0, dice1} + {1'b0, dice2};
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_dice_roller.sv
// Self-checking bench for dice_roller: an edge-count schedule model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_dice_roller;

    localparam int TD = 4;
    localparam int RU = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       roll  = 1'b0;
    logic [2:0] dice1, dice2;
    logic       clock_en;
    logic [3:0] sum;
    logic       busy, done;

    int checks = 0;
    int errors = 0;
    int ce_cnt = 0;
    int done_cnt = 0;

    dice_roller #(.TUMBLE_DIV(TD), .ROLL_UPDATES(RU)) dut (
        .clock    (clock),
        .reset    (reset),
        .roll     (roll),
        .dice1    (dice1),
        .dice2    (dice2),
        .clock_en (clock_en),
        .sum      (sum),
        .busy     (busy),
        .done     (done)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: pair index = edges since reset mod 36; a roll started at edge E0
    // updates at E0+k*TD (k=1..RU) and completes at E0+RU*TD+1.
    bit model_valid = 0;
    int pidx = 0;
    bit roll_prev = 0;
    bit active = 0;
    int rel = 0;
    int m_d1 = 1, m_d2 = 1, m_sum = 2;
    bit m_ce = 0, m_done = 0;

    always @(posedge clock) begin
        if (reset) begin
            model_valid = 1;
            pidx = 0; roll_prev = 0; active = 0; rel = 0;
            m_d1 = 1; m_d2 = 1; m_sum = 2; m_ce = 0; m_done = 0;
        end else begin
            m_ce = 0;
            m_done = 0;
            if (active) begin
                rel++;
                if (rel % TD == 0 && rel <= RU * TD) begin
                    m_ce = 1;
                    m_d1 = pidx % 6 + 1;
                    m_d2 = pidx / 6 + 1;
                end
                if (rel == RU * TD + 1) begin
                    m_done = 1;
                    m_sum = m_d1 + m_d2;
                    active = 0;
                end
            end else if (roll && !roll_prev) begin
                active = 1;
                rel = 0;
            end
            roll_prev = roll;
            pidx = (pidx + 1) % 36;
        end
    end

    always @(negedge clock) begin
        if (model_valid) begin
            check("dice1", int'(dice1), m_d1);
            check("dice2", int'(dice2), m_d2);
            check("sum", int'(sum), m_sum);
            check("clock_en", int'(clock_en), int'(m_ce));
            check("done", int'(done), int'(m_done));
            check("busy", int'(busy), int'(active));
            if (clock_en === 1'b1) ce_cnt++;
            if (done === 1'b1) done_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        roll  = 1'b0;
        tick(2);
        reset = 1'b0;
    endtask

    task automatic wait_done(input int limit, output bit ok);
        ok = 0;
        for (int k = 0; k < limit && !ok; k++) begin
            @(negedge clock);
            if (done === 1'b1) ok = 1;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok;
        int ce_base, done_base, seen3, idx, d1, d2;
        int seen[0:7][0:7];

        for (int a = 0; a < 8; a++)
            for (int b = 0; b < 8; b++)
                seen[a][b] = 0;

        // Reset state
        do_reset();
        check("rst_dice1", int'(dice1), 1);
        check("rst_dice2", int'(dice2), 1);
        check("rst_sum", int'(sum), 2);
        check("rst_busy", int'(busy), 0);
        check("rst_clock_en", int'(clock_en), 0);
        check("rst_done", int'(done), 0);

        // Nominal roll: rise sampled at first edge after release -> i=32 -> (3,6)
        do_reset();
        ce_base = ce_cnt; done_base = done_cnt;
        roll = 1'b1;
        tick(1);
        roll = 1'b0;
        wait_done(200, ok);
        check("nom_done_seen", int'(ok), 1);
        check("nom_dice1", int'(dice1), 3);
        check("nom_dice2", int'(dice2), 6);
        check("nom_sum", int'(sum), 9);
        tick(2);
        check("nom_ce_pulses", ce_cnt - ce_base, 8);
        check("nom_done_pulses", done_cnt - done_base, 1);

        // Held roll
        do_reset();
        ce_base = ce_cnt; done_base = done_cnt;
        roll = 1'b1;
        tick(100);
        roll = 1'b0;
        tick(5);
        check("held_ce_pulses", ce_cnt - ce_base, 8);
        check("held_done_pulses", done_cnt - done_base, 1);

        // Busy rejection
        do_reset();
        ce_base = ce_cnt; done_base = done_cnt;
        roll = 1'b1;
        tick(1);
        roll = 1'b0;
        tick(9);
        roll = 1'b1;
        tick(2);
        roll = 1'b0;
        wait_done(200, ok);
        check("busy_done_seen", int'(ok), 1);
        tick(40);
        check("busy_ce_pulses", ce_cnt - ce_base, 8);
        check("busy_done_pulses", done_cnt - done_base, 1);

        // Mid-roll reset after third clock_en
        do_reset();
        roll = 1'b1;
        tick(1);
        roll = 1'b0;
        seen3 = 0;
        for (int k = 0; k < 200 && seen3 < 3; k++) begin
            @(negedge clock);
            if (clock_en === 1'b1) seen3++;
        end
        check("mid_third_ce_seen", seen3, 3);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("mid_dice1", int'(dice1), 1);
        check("mid_dice2", int'(dice2), 1);
        check("mid_busy", int'(busy), 0);
        ce_base = ce_cnt; done_base = done_cnt;
        tick(60);
        check("mid_no_ce", ce_cnt - ce_base, 0);
        check("mid_no_done", done_cnt - done_base, 0);

        // Exhaustive: start edge m after release gives final index (m+31) mod 36
        for (int m = 1; m <= 36; m++) begin
            do_reset();
            tick(m - 1);
            roll = 1'b1;
            tick(1);
            roll = 1'b0;
            wait_done(200, ok);
            check("exh_done_seen", int'(ok), 1);
            idx = (m + 31) % 36;
            d1 = int'(dice1);
            d2 = int'(dice2);
            check("exh_dice1", d1, idx % 6 + 1);
            check("exh_dice2", d2, idx / 6 + 1);
            check("exh_sum_range", int'(sum >= 4'd2 && sum <= 4'd12), 1);
            if (d1 >= 0 && d1 <= 7 && d2 >= 0 && d2 <= 7)
                seen[d1][d2]++;
        end
        for (int a = 1; a <= 6; a++)
            for (int b = 1; b <= 6; b++)
                check($sformatf("exh_pair_%0d_%0d", a, b), seen[a][b], 1);

        // Randomized roll traffic with occasional resets
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 3) == 0) roll = ~roll;
            reset = ($urandom_range(0, 399) == 0);
            tick(1);
        end
        reset = 1'b0;
        roll = 1'b0;
        tick(50);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dice_roller.md
DICE_ROLLER -- requirements
Module: dice_roller

Interface
REQ-001 Parameter TUMBLE_DIV, default 4: clock cycles between successive tumble updates; legal range 1..255.
REQ-002 Parameter ROLL_UPDATES, default 8: tumble updates per roll; legal range 1..255.
REQ-003 clock  input  1  system clock; all state changes on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 roll  input  1  roll request, level; already synchronized to clock.
REQ-006 dice1  output  3  face of die 1, encoded 1..6; feeds the 7-segment display block.
REQ-007 dice2  output  3  face of die 2, encoded 1..6; feeds the 7-segment display block.
REQ-008 clock_en  output  1  display-update strobe, one cycle high per dice1/dice2 change.
REQ-009 sum  output  4  dice1+dice2 of the last completed roll, 2..12.
REQ-010 busy  output  1  high while a roll is in progress.
REQ-011 done  output  1  one-cycle pulse marking roll completion.

Function
REQ-012 Free-running pair counter c1/c2 (each 1..6) SHALL advance every cycle in all states: c1 steps 1..6 and wraps to 1; c2 steps only when c1 wraps from 6; c2 wraps 6->1, giving 36 combinations.
REQ-013 Pair index i = 6*(c2-1)+(c1-1) SHALL be 0 after reset and equal n mod 36 after n edges with reset low.
REQ-014 roll_q SHALL register roll each cycle; rise = roll & ~roll_q.
REQ-015 FSM states IDLE, ROLL, DONE; busy SHALL be 1 exactly in ROLL and DONE.
REQ-016 IDLE: at an edge sampling rise=1, SHALL enter ROLL with div=0 and upd=0; otherwise stay in IDLE.
REQ-017 ROLL: at each edge, if div==TUMBLE_DIV-1 then div<=0, dice1<=c1, dice2<=c2, clock_en<=1, upd<=upd+1; else div<=div+1 and clock_en<=0.
REQ-018 ROLL: the edge performing update number ROLL_UPDATES SHALL also move the FSM to DONE.
REQ-019 Roll entered at edge E0: updates SHALL occur at edges E0+k*TUMBLE_DIV, k=1..ROLL_UPDATES; final faces SHALL equal the counter values sampled at edge E0+ROLL_UPDATES*TUMBLE_DIV.
REQ-020 DONE: at one edge, done<=1, sum<=dice1+dice2 (4-bit, no overflow), FSM<=IDLE; done SHALL be high exactly the cycle after the last clock_en pulse.
REQ-021 clock_en and done SHALL be 0 in every other cycle.
REQ-022 dice1, dice2 and sum SHALL hold between rolls and never take values 0 or 7.
REQ-023 A roll rise while busy SHALL be ignored and not queued; roll held high SHALL start exactly one roll.
REQ-024 Starting a second roll SHALL require roll to return low and then rise again while in IDLE.

Reset
REQ-025 On an edge with reset=1, every register SHALL take its reset value; reset SHALL override all other activity, including mid-roll.
REQ-026 Reset values: FSM=IDLE, c1=c2=1, dice1=dice2=1, sum=2, clock_en=0, done=0, busy=0, roll_q=0, div=0, upd=0.
REQ-027 After reset mid-roll, no further clock_en or done SHALL occur until a new rise.

Structure
REQ-028 Shared package craps_pkg SHALL hold DIE_MIN=1, DIE_MAX=6, the die face width (3) and the FSM state encoding.
REQ-029 The c1/c2 pair counter SHALL be a sub-module named die_pair_counter (clock, reset, c1, c2); the FSM, divider and output registers stay in dice_roller.

Verification
REQ-030 Reset: assert reset for 2 cycles -> dice1=1, dice2=1, sum=2, busy=0, clock_en=0, done=0.
REQ-031 Nominal roll (defaults): roll rise sampled at 1st edge after reset release -> 8 clock_en pulses, 4 cycles apart; final dice1=3, dice2=6 (i=32); done one cycle later; sum=9.
REQ-032 Held roll: roll held high for 100 cycles -> exactly one roll (8 clock_en pulses, one done).
REQ-033 Busy rejection: second roll rise 10 cycles into a roll -> ignored; only 8 clock_en pulses and one done.
REQ-034 Mid-roll reset: reset after the 3rd clock_en -> dice1=1, dice2=1, busy=0; no further clock_en or done.
REQ-035 Exhaustive: 36 rolls started at successive counter phases -> every (dice1,dice2) pair in 1..6 seen once; sum always 2..12; a scoreboard checks each result.
